// File: rtl/SystolicTypes.sv
// Shared types for the systolic array memory responder.
//   memory_status_t : activity status reported to the system status logic
//   error_code_t    : sticky error reported alongside the status
//   port_tag_t      : identifies which port a read beat belongs to
//   sat_inc16       : saturating 16-bit increment for the access counters
package SystolicTypes;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_READING = 2'd1,
        MEM_WRITING = 2'd2,
        MEM_ERROR   = 2'd3
    } memory_status_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_ADDR_RANGE  = 2'd1,
        ERR_RW_CONFLICT = 2'd2
    } error_code_t;

    typedef enum logic {
        PORT_ARRAY = 1'b0,
        PORT_HOST  = 1'b1
    } port_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/systolic_rd_pipe.sv
// Read-return delay line shared by the array and host ports.
// A request enters at stage 0 together with its port tag and a "force zero"
// flag (out-of-range read). RAM data arrives one cycle later from the
// registered RAM output and is carried for the remaining LAT-1 stages.
// Ports:
//   clk          : clock
//   flush_i      : synchronous flush, drops every beat in flight
//   in_valid_i   : a read beat enters the line this cycle
//   in_tag_i     : port the beat belongs to
//   in_zero_i    : beat returns 0 instead of RAM data
//   ram_data_i   : registered RAM read data (valid one cycle after request)
//   out_valid_o  : beat emerges this cycle (LAT cycles after request)
//   out_tag_o    : port of the emerging beat
//   out_data_o   : data of the emerging beat
//   busy_o       : at least one beat is somewhere in the line
module systolic_rd_pipe
    import SystolicTypes::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  port_tag_t        in_tag_i,
    input  logic             in_zero_i,
    input  logic [WIDTH-1:0] ram_data_i,
    output logic             out_valid_o,
    output port_tag_t        out_tag_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);

    logic [LAT-1:0]   vld_q;
    port_tag_t        tag_q [LAT];
    logic             zero_q;
    logic [WIDTH-1:0] data_s1;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_ctl
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (flush_i) begin
                        vld_q[0] <= 1'b0;
                    end else begin
                        vld_q[0] <= in_valid_i;
                    end
                    tag_q[0] <= in_tag_i;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (flush_i) begin
                        vld_q[gi] <= 1'b0;
                    end else begin
                        vld_q[gi] <= vld_q[gi-1];
                    end
                    tag_q[gi] <= tag_q[gi-1];
                end
            end
        end
    endgenerate

    // The zero flag travels with stage 0 so it lines up with the RAM output.
    always_ff @(posedge clk) begin
        zero_q <= in_zero_i;
    end

    assign data_s1 = zero_q ? '0 : ram_data_i;

    generate
        if (LAT == 1) begin : g_lat1
            assign out_data_o = data_s1;
        end else begin : g_latn
            logic [WIDTH-1:0] data_q [LAT-1];
            for (gi = 0; gi < LAT - 1; gi++) begin : g_data
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        data_q[0] <= data_s1;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        data_q[gi] <= data_q[gi-1];
                    end
                end
            end
            assign out_data_o = data_q[LAT-2];
        end
    endgenerate

    assign out_valid_o = vld_q[LAT-1];
    assign out_tag_o   = tag_q[LAT-1];
    assign busy_o      = |vld_q;

endmodule

// File: rtl/systolic_mem_responder.sv
// Memory-side responder for the systolic array controller.
// Serves array word reads/writes with absolute priority and a host port for
// preload/readback when the array is idle; one shared synchronous RAM.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   act_addr, mem_read_en,
//   mem_write, mem_data_write    : array request
//   mem_read, rd_valid           : array read return (READ_LAT cycles later)
//   host_re, host_we, host_addr,
//   host_wdata                   : host request (ignored unless host_ready)
//   host_rdata, host_rvalid      : host read return
//   host_ready                   : no array strobe this cycle
//   error_clr                    : clears the sticky error
//   memory_status, error_code    : registered status / sticky first error
//   rd_count, wr_count           : saturating array access counters
module systolic_mem_responder
    import SystolicTypes::*;
#(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] act_addr,
    input  logic              mem_read_en,
    input  logic              mem_write,
    input  logic [WIDTH-1:0]  mem_data_write,
    output logic [WIDTH-1:0]  mem_read,
    output logic              rd_valid,
    input  logic              host_re,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic [WIDTH-1:0]  host_rdata,
    output logic              host_rvalid,
    output logic              host_ready,
    input  logic              error_clr,
    output memory_status_t    memory_status,
    output error_code_t       error_code,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // ---------------- request selection ----------------
    logic              arr_req;
    logic              req_re;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    port_tag_t         req_tag;
    logic              in_range;
    logic              wr_go;
    logic              rd_issue;
    logic              rd_go;
    logic [IDX_W-1:0]  req_idx;

    assign arr_req    = mem_read_en | mem_write;
    assign host_ready = ~arr_req;

    // Host strobes are simply not looked at while the array is active.
    assign req_re    = arr_req ? mem_read_en    : host_re;
    assign req_we    = arr_req ? mem_write      : host_we;
    assign req_addr  = arr_req ? act_addr       : host_addr;
    assign req_wdata = arr_req ? mem_data_write : host_wdata;
    assign req_tag   = arr_req ? PORT_ARRAY     : PORT_HOST;

    assign in_range = {1'b0, req_addr} < DEPTH_LIM;
    assign req_idx  = req_addr[IDX_W-1:0];

    // Nothing lands while reset is held; a read alongside a write is dropped.
    assign wr_go    = rst & req_we & in_range;
    assign rd_issue = rst & req_re & ~req_we;
    assign rd_go    = rd_issue & in_range;

    // ---------------- storage ----------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] ram_rdata_q;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_q[req_idx] <= req_wdata;
        end
        if (rd_go) begin
            ram_rdata_q <= wr_go ? req_wdata : mem_q[req_idx];
        end
    end

    // ---------------- read return ----------------
    logic             pipe_valid;
    port_tag_t        pipe_tag;
    logic [WIDTH-1:0] pipe_data;
    logic             pipe_busy;
    logic             arr_beat;
    logic             host_beat;
    logic [WIDTH-1:0] mem_read_q;
    logic [WIDTH-1:0] host_rdata_q;

    systolic_rd_pipe #(
        .WIDTH (WIDTH),
        .LAT   (READ_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .flush_i     (~rst),
        .in_valid_i  (rd_issue),
        .in_tag_i    (req_tag),
        .in_zero_i   (~in_range),
        .ram_data_i  (ram_rdata_q),
        .out_valid_o (pipe_valid),
        .out_tag_o   (pipe_tag),
        .out_data_o  (pipe_data),
        .busy_o      (pipe_busy)
    );

    assign arr_beat  = pipe_valid & (pipe_tag == PORT_ARRAY);
    assign host_beat = pipe_valid & (pipe_tag == PORT_HOST);

    assign rd_valid    = arr_beat;
    assign host_rvalid = host_beat;
    // Between beats each port keeps presenting its last returned word.
    assign mem_read    = arr_beat  ? pipe_data : mem_read_q;
    assign host_rdata  = host_beat ? pipe_data : host_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_read_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            if (arr_beat) begin
                mem_read_q <= pipe_data;
            end
            if (host_beat) begin
                host_rdata_q <= pipe_data;
            end
        end
    end

    // ---------------- counters ----------------
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_go && arr_req) begin
            rd_count_d = sat_inc16(rd_count_q);
        end
        if (wr_go && arr_req) begin
            wr_count_d = sat_inc16(wr_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    // ---------------- sticky error ----------------
    error_code_t error_q, error_d, err_new;

    always_comb begin
        err_new = ERR_NONE;
        if (req_re && req_we) begin
            err_new = ERR_RW_CONFLICT;
        end else if ((req_re || req_we) && !in_range) begin
            err_new = ERR_ADDR_RANGE;
        end
    end

    // A clear frees the register, and a same-cycle new error then takes it.
    always_comb begin
        error_d = error_q;
        if (error_clr) begin
            error_d = ERR_NONE;
        end
        if (err_new != ERR_NONE && (error_q == ERR_NONE || error_clr)) begin
            error_d = err_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= ERR_NONE;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_code = error_q;

    // ---------------- status FSM ----------------
    memory_status_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Uses the next error value so MEM_ERROR appears together with error_code.
    always_comb begin
        state_d = MEM_IDLE;
        if (error_d != ERR_NONE) begin
            state_d = MEM_ERROR;
        end else if (req_we) begin
            state_d = MEM_WRITING;
        end else if (req_re || pipe_busy) begin
            state_d = MEM_READING;
        end
    end

    always_comb begin
        memory_status = state_q;
    end

endmodule

// File: tb/tb_systolic_mem_responder.sv
module tb_systolic_mem_responder;
    import SystolicTypes::*;

    localparam int W   = 16;
    localparam int AW  = 12;
    localparam int D   = 64;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] act_addr;
    logic          mem_read_en;
    logic          mem_write;
    logic [W-1:0]  mem_data_write;
    logic [W-1:0]  mem_read;
    logic          rd_valid;
    logic          host_re;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [W-1:0]  host_wdata;
    logic [W-1:0]  host_rdata;
    logic          host_rvalid;
    logic          host_ready;
    logic          error_clr;
    memory_status_t memory_status;
    error_code_t   error_code;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    systolic_mem_responder #(
        .WIDTH    (W),
        .ADDR_W   (AW),
        .DEPTH    (D),
        .READ_LAT (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .act_addr       (act_addr),
        .mem_read_en    (mem_read_en),
        .mem_write      (mem_write),
        .mem_data_write (mem_data_write),
        .mem_read       (mem_read),
        .rd_valid       (rd_valid),
        .host_re        (host_re),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .host_ready     (host_ready),
        .error_clr      (error_clr),
        .memory_status  (memory_status),
        .error_code     (error_code),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    // Reference model: word array plus a queue of promised read beats.
    typedef struct {
        int          due;
        bit          host;
        logic [15:0] data;
    } beat_t;

    beat_t          beats[$];
    logic [15:0]    mem_m [D];
    logic [15:0]    hold_a, hold_h, rdc_m, wrc_m;
    error_code_t    err_m;
    memory_status_t st_m;
    int             cyc;
    int             total = 0;
    int             bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        mem_read_en    = 1'b0;
        mem_write      = 1'b0;
        act_addr       = '0;
        mem_data_write = '0;
        host_re        = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        error_clr      = 1'b0;
    endtask

    task automatic model_reset();
        beats.delete();
        hold_a = '0;
        hold_h = '0;
        rdc_m  = '0;
        wrc_m  = '0;
        err_m  = ERR_NONE;
        st_m   = MEM_IDLE;
    endtask

    // Applies this cycle's (already driven) inputs to the model at the edge.
    task automatic model_edge();
        bit          arr, re, we, oor, flight;
        logic [11:0] a;
        logic [15:0] wd, dv;
        error_code_t new_e;
        if (!rst) begin
            model_reset();
            return;
        end
        flight = beats.size() != 0;
        if (beats.size() > 0 && beats[0].due == cyc) begin
            if (beats[0].host) hold_h = beats[0].data;
            else               hold_a = beats[0].data;
            void'(beats.pop_front());
        end
        arr = mem_read_en | mem_write;
        re  = arr ? mem_read_en : host_re;
        we  = arr ? mem_write : host_we;
        a   = arr ? act_addr : host_addr;
        wd  = arr ? mem_data_write : host_wdata;
        oor = int'(a) >= D;
        new_e = ERR_NONE;
        if (re && we)             new_e = ERR_RW_CONFLICT;
        else if ((re || we) && oor) new_e = ERR_ADDR_RANGE;
        if (we && !oor) begin
            mem_m[a] = wd;
            if (arr && wrc_m != 16'hFFFF) wrc_m++;
        end
        if (re && !we) begin
            dv = 16'h0;
            if (!oor) dv = mem_m[a];
            beats.push_back('{due: cyc + LAT, host: !arr, data: dv});
            if (arr && !oor && rdc_m != 16'hFFFF) rdc_m++;
        end
        if (new_e != ERR_NONE && (err_m == ERR_NONE || error_clr)) err_m = new_e;
        else if (error_clr) err_m = ERR_NONE;
        if (err_m != ERR_NONE)     st_m = MEM_ERROR;
        else if (we)               st_m = MEM_WRITING;
        else if (re || flight)     st_m = MEM_READING;
        else                       st_m = MEM_IDLE;
    endtask

    // One clock cycle: check outputs mid-cycle, update model at the edge.
    task automatic tick();
        bit          av, hv;
        logic [15:0] ea, eh;
        @(negedge clk);
        av = beats.size() > 0 && beats[0].due == cyc && !beats[0].host;
        hv = beats.size() > 0 && beats[0].due == cyc && beats[0].host;
        ea = av ? beats[0].data : hold_a;
        eh = hv ? beats[0].data : hold_h;
        chk("host_ready", host_ready, !(mem_read_en | mem_write));
        chk("rd_valid", rd_valid, av);
        chk("mem_read", mem_read, ea);
        chk("host_rvalid", host_rvalid, hv);
        chk("host_rdata", host_rdata, eh);
        chk("memory_status", memory_status, st_m);
        chk("error_code", error_code, err_m);
        chk("rd_count", rd_count, rdc_m);
        chk("wr_count", wr_count, wrc_m);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        clear_in();
    endtask

    task automatic arr_rd(input logic [11:0] a);
        mem_read_en = 1'b1; act_addr = a; tick();
    endtask

    task automatic arr_wr(input logic [11:0] a, input logic [15:0] d);
        mem_write = 1'b1; act_addr = a; mem_data_write = d; tick();
    endtask

    task automatic host_wr(input logic [11:0] a, input logic [15:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d; tick();
    endtask

    task automatic host_rd(input logic [11:0] a);
        host_re = 1'b1; host_addr = a; tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clear_in();
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", mem_read, 16'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_host_rdata", host_rdata, 16'h0);
        chk("rst_host_rvalid", host_rvalid, 1'b0);
        chk("rst_status", memory_status, MEM_IDLE);
        chk("rst_error", error_code, ERR_NONE);
        chk("rst_rd_count", rd_count, 16'h0);
        chk("rst_wr_count", wr_count, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Preload: random background, operands 1..16, C results at 32..47.
        for (int i = 0; i < D; i++) host_wr(12'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) host_wr(12'(i), 16'(i + 1));
        for (int i = 0; i < 16; i++) host_wr(12'(32 + i), 16'((i + 1) * (i + 3)));
        host_rd(12'd3);
        host_rd(12'd40);
        idle(3);

        // Array streams 0..15 back to back.
        for (int i = 0; i < 16; i++) arr_rd(12'(i));
        idle(3);
        chk("stream_rd_count", rd_count, 16'd16);

        // Array write -5 then read next cycle.
        arr_wr(12'd32, 16'hFFFB);
        arr_rd(12'd32);
        idle(3);
        chk("wr_then_rd", mem_read, 16'hFFFB);
        chk("wr_count_one", wr_count, 16'd1);

        // Read/write conflict.
        mem_read_en = 1'b1; mem_write = 1'b1; act_addr = 12'd40; mem_data_write = 16'd7;
        tick();
        chk("conflict_err", error_code, ERR_RW_CONFLICT);
        chk("conflict_status", memory_status, MEM_ERROR);
        idle(3);
        error_clr = 1'b1;
        tick();
        chk("clr_err", error_code, ERR_NONE);
        chk("clr_status", memory_status, MEM_IDLE);
        arr_rd(12'd40);
        idle(3);
        chk("conflict_wrote", mem_read, 16'd7);

        // Out of range read and write.
        arr_rd(12'd100);
        idle(3);
        chk("oor_err", error_code, ERR_ADDR_RANGE);
        chk("oor_data", mem_read, 16'h0);
        arr_wr(12'd100, 16'($urandom));
        error_clr = 1'b1;
        tick();
        for (int i = 0; i < D; i++) arr_rd(12'(i));
        idle(3);

        // Randomized mix of both ports.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            act_addr       = 12'($urandom_range(0, 70));
            mem_data_write = 16'($urandom);
            if (r < 6)       mem_read_en = 1'b1;
            else if (r < 10) mem_write = 1'b1;
            else if (r == 10) begin mem_read_en = 1'b1; mem_write = 1'b1; end
            host_re    = ($urandom_range(0, 2) == 0);
            host_we    = ($urandom_range(0, 3) == 0);
            host_addr  = 12'($urandom_range(0, 70));
            host_wdata = 16'($urandom);
            error_clr  = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle(4);
        error_clr = 1'b1;
        tick();

        // Host write held while the array reads, then it lands.
        for (int i = 0; i < 3; i++) begin
            mem_read_en = 1'b1; act_addr = 12'(i);
            host_we = 1'b1; host_addr = 12'd5; host_wdata = 16'h1234;
            tick();
        end
        host_wr(12'd5, 16'h1234);
        host_rd(12'd5);
        idle(3);
        chk("host_landed", host_rdata, 16'h1234);

        // Reset with reads in flight.
        host_wr(12'd0, 16'd1);
        arr_rd(12'd0);
        arr_rd(12'd1);
        rst = 1'b0; mem_read_en = 1'b1; act_addr = 12'd2;
        tick();
        rst = 1'b1;
        chk("rst_mid_rd_count", rd_count, 16'h0);
        chk("rst_mid_wr_count", wr_count, 16'h0);
        arr_rd(12'd0);
        idle(3);
        chk("mem0_kept", mem_read, 16'd1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_mem_responder.md
# systolic_mem_responder

Memory-side responder for the systolic array controller: it answers the controller's word reads, which load operand matrices A and B, and absorbs its result writes to C. It holds a synchronous word memory and returns read data after a fixed pipeline latency. It reports `memory_status_t` / `error_code_t` to the system status logic. A secondary host port preloads operands and reads back results while the array is idle.

## Interface
- `WIDTH`, 16: data word width (signed).
- `ADDR_W`, 12: address width; matches `act_addr`.
- `DEPTH`, 4096: implemented words; addresses ≥ DEPTH are out of range.
- `READ_LAT`, 1: read latency in cycles, legal 1..4.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `act_addr`  in  ADDR_W  array request address.
- `mem_read_en`  in  1  array read strobe.
- `mem_write`  in  1  array write strobe.
- `mem_data_write`  in  WIDTH  array write data.
- `mem_read`  out  WIDTH  read data to array.
- `rd_valid`  out  1  `mem_read` valid this cycle.
- `host_re`, `host_we`  in  1  host read/write strobes.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  WIDTH  host write data.
- `host_rdata`  out  WIDTH  host read data.
- `host_rvalid`  out  1  `host_rdata` valid.
- `host_ready`  out  1  combinational; high when no array strobe this cycle.
- `error_clr`  in  1  clears sticky `error_code`.
- `memory_status`  out  `memory_status_t`  registered activity status.
- `error_code`  out  `error_code_t`  sticky first error.
- `rd_count`, `wr_count`  out  16  saturating array-access counters.

## Operation
- **Arbitration:** the array has absolute priority.
  - `host_ready = !(mem_read_en | mem_write)`.
  - A host strobe while `host_ready` is 0 is ignored; the host holds it until ready.
- **Array write:** `mem_write` with an in-range address writes `mem_data_write` at the clock edge. `wr_count` increments and saturates at 0xFFFF.
- **Array read:** `mem_read_en` with an in-range address enters the read pipe.
  - After `READ_LAT` cycles: `rd_valid`=1 and `mem_read` = word content.
  - `rd_count` increments and saturates at 0xFFFF.
- **Read/write conflict:** `mem_read_en` and `mem_write` both high in the same cycle.
  - The write is performed.
  - The read is dropped: no `rd_valid` is produced for it.
  - `error_code` latches `ERR_RW_CONFLICT`.
- **Out of range:** any address ≥ DEPTH, from either port.
  - A write is dropped.
  - A read still produces a valid beat with data 0.
  - `error_code` latches `ERR_ADDR_RANGE`.
- **Sticky error:** `error_code` holds the first error until `error_clr` or reset. If `error_clr` and a new error occur in the same cycle, the new error wins.
- **Status FSM:** `memory_status` updates each cycle from that cycle's activity.
  - `MEM_IDLE`: no accepted access.
  - `MEM_READING`: array read accepted or a read beat in flight.
  - `MEM_WRITING`: array write accepted (takes precedence over reading).
  - `MEM_ERROR`: whenever `error_code != ERR_NONE`; overrides all other states.
- **Host port:** same rules as the array port, including range check and latency.
  - Host accesses do not update `rd_count`/`wr_count`.
  - Host accesses do drive `memory_status`.

## Timing
- **Read latency:** request in cycle t gives `rd_valid`/`mem_read` in cycle t+READ_LAT.
  - Fully pipelined: one read accepted per cycle.
  - Valid beats are returned in request order.
- **Write-then-read:** a write in cycle t followed by a read of the same address in t+1 returns the new data.
- **Reset values** (`rst`=0 at an edge): `mem_read`=0, `rd_valid`=0, `host_rdata`=0, `host_rvalid`=0, `memory_status`=`MEM_IDLE`, `error_code`=`ERR_NONE`, counters 0.
- **Reset mid-operation:**
  - The read pipe is flushed; in-flight beats never appear.
  - Memory contents are not cleared.
  - The first request after reset release is accepted in that same cycle.
- **Data hold:** `mem_read` holds its last valid value when `rd_valid`=0.

## Structure
- `SystolicTypes` package gains or confirms these enums:
  - `memory_status_t`: `MEM_IDLE`, `MEM_READING`, `MEM_WRITING`, `MEM_ERROR`.
  - `error_code_t`: `ERR_NONE`, `ERR_ADDR_RANGE`, `ERR_RW_CONFLICT`.
- Sub-module `systolic_rd_pipe`: a `READ_LAT`-deep valid/data/port-tag delay line with synchronous flush, instantiated once for both ports.
- The storage array stays in the top-level module: a single-write, single-read synchronous RAM with write-first behaviour.

## Test plan
- **Preload and read back:** host writes 1..16 to addresses 0..15 and A·B = C results are written to 32..47; the array reads 0..15 back-to-back with `READ_LAT`=2 → 16 consecutive `rd_valid` beats, data 1..16, first beat 2 cycles after the first request, `rd_count`=16.
- **Array writes:** array writes −5 to address 32 then reads 32 in the next cycle → `mem_read`=−5 (0xFFFB); `wr_count`=1.
- **Read/write conflict:** `mem_read_en` and `mem_write` both high at address 40 with data 7 → no `rd_valid` for that read, mem[40]=7, `error_code`=`ERR_RW_CONFLICT`, `memory_status`=`MEM_ERROR`; after `error_clr` → `ERR_NONE`, `MEM_IDLE`.
- **Out of range:** DEPTH=64, array read at address 100 → `rd_valid` beat with data 0, `error_code`=`ERR_ADDR_RANGE`; a write to 100 leaves addresses 0..63 unchanged.
- **Host blocked, then reset mid-read:** host write held while the array reads → `host_ready`=0 until the array goes idle, then the host write lands. Assert `rst`=0 with 2 reads in flight → no `rd_valid` afterwards, counters 0, mem[0] still 1.
